// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: active-low glyphs
// {g,f,e,d,c,b,a}, anode patterns and the slot index type.
package seg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;

    function automatic logic [3:0] an_for_slot(slot_t s);
        case (s)
            2'd0:    return AN_SLOT0;
            2'd1:    return AN_SLOT1;
            2'd2:    return AN_SLOT2;
            default: return AN_SLOT3;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Bundle between the stopwatch counter / blink divider and the display scanner.
interface seg_display_scan_if;
    logic       clk_2hz;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output clk_2hz, min_t, min_o, sec_t, sec_o, adj, sel,
        input  an, seg, dp
    );

    modport slave (
        input  clk_2hz, min_t, min_o, sec_t, sec_o, adj, sel,
        output an, seg, dp
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot anti-ghost blanking
// and adjust-mode field blinking. All outputs are registered.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_scan_if.slave  scan_if
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            idx_q, idx_d;
    logic             sync1_q, sync2_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             cnt_wrap;
    logic [3:0]       digit;
    logic [6:0]       glyph;
    logic             field_blank;

    assign cnt_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    assign idx_d    = cnt_wrap ? slot_t'(idx_q + 2'd1) : idx_q;

    always_comb begin
        case (idx_q)
            2'd0:    digit = scan_if.sec_o;
            2'd1:    digit = scan_if.sec_t;
            2'd2:    digit = scan_if.min_o;
            default: digit = scan_if.min_t;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (glyph)
    );

    // Slots 0-1 hold seconds, 2-3 minutes: idx_q[1] picks the field.
    assign field_blank = scan_if.adj & sync2_q & (scan_if.sel ? ~idx_q[1] : idx_q[1]);

    always_comb begin
        an_d  = (cnt_q < CNT_W'(BLANK_CYC)) ? AN_OFF : an_for_slot(idx_q);
        seg_d = field_blank ? SEG_OFF : glyph;
        dp_d  = field_blank ? 1'b1 : (idx_q != 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync1_q <= scan_if.clk_2hz;
            sync2_q <= sync1_q;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign scan_if.an  = an_q;
    assign scan_if.seg = seg_q;
    assign scan_if.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle-count based reference model
// predicts every output frame, a negedge monitor pops and compares.
module tb_seg_display_scan;

    localparam int SD = 4;
    localparam int BC = 1;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_display_scan_if ifc ();

    seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk     (clk),
        .rst     (rst),
        .scan_if (ifc.slave)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   t      = 0;
    bit   c2_hist[$];
    exp_t sbq[$];
    exp_t mon_e;

    logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(string name, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (time %0t, t=%0d)", name, act, req, $time, t);
    endtask

    // Expected outputs after edge tt (counted from reset release), given the
    // inputs presented before that edge and the blink phase seen two edges ago.
    function automatic exp_t model(int tt, bit blink);
        exp_t       e;
        int         slot = (tt / SD) % 4;
        int         pos  = tt % SD;
        logic [3:0] d;
        bit         field;
        case (slot)
            0:       d = ifc.sec_o;
            1:       d = ifc.sec_t;
            2:       d = ifc.min_o;
            default: d = ifc.min_t;
        endcase
        field = ifc.adj && blink && (ifc.sel ? (slot < 2) : (slot >= 2));
        e.an  = (pos < BC) ? 4'hF : (4'hF ^ (4'b0001 << slot));
        e.seg = field ? 7'h7F : ((d > 9) ? 7'h3F : GLYPH[d]);
        e.dp  = field ? 1'b1 : (slot != 2);
        return e;
    endfunction

    task automatic step();
        bit blink;
        blink = (t >= 2) ? c2_hist[t-2] : 1'b0;
        sbq.push_back(model(t, blink));
        c2_hist.push_back(ifc.clk_2hz);
        @(posedge clk);
        t++;
        #1;
    endtask

    task automatic async_reset_mid(string tag);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk({tag, "_an"},  ifc.an,  4'hF);
        chk({tag, "_seg"}, ifc.seg, 7'h7F);
        chk({tag, "_dp"},  ifc.dp,  1);
        chk({tag, "_sbq"}, sbq.size(), 0);
        @(posedge clk);
        #1;
        chk({tag, "_hold_an"}, ifc.an, 4'hF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        t   = 0;
        c2_hist.delete();
    endtask

    always @(negedge clk) begin
        if (rst && sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("an",  ifc.an,  mon_e.an);
            chk("seg", ifc.seg, mon_e.seg);
            chk("dp",  ifc.dp,  mon_e.dp);
        end
    end

    initial begin
        ifc.min_t   = 4'd1;
        ifc.min_o   = 4'd2;
        ifc.sec_t   = 4'd3;
        ifc.sec_o   = 4'd4;
        ifc.adj     = 1'b0;
        ifc.sel     = 1'b0;
        ifc.clk_2hz = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_an",  ifc.an,  4'hF);
        chk("reset_seg", ifc.seg, 7'h7F);
        chk("reset_dp",  ifc.dp,  1);
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Scan order with digits 1,2,3,4
        repeat (2 * 4 * SD) step();

        // Non-BCD digit in slot 0
        ifc.sec_o = 4'hC;
        repeat (4 * SD) step();
        ifc.sec_o = 4'd4;

        // Blink seconds, then release the blink phase
        ifc.adj = 1'b1; ifc.sel = 1'b1; ifc.clk_2hz = 1'b1;
        repeat (4 * SD + 2) step();
        ifc.clk_2hz = 1'b0;
        repeat (4 * SD) step();

        // Blink minutes, then leave adjust mode
        ifc.sel = 1'b0; ifc.clk_2hz = 1'b1;
        repeat (4 * SD + 2) step();
        ifc.adj = 1'b0;
        repeat (4 * SD) step();

        // Async reset in the middle of slot 2
        for (int i = 0; i < 40 && !(((t / SD) % 4) == 2 && (t % SD) == 2); i++) step();
        chk("reached_slot2", ((t / SD) % 4) * 10 + (t % SD), 22);
        ifc.sec_o = 4'd5;
        async_reset_mid("rst_mid");

        // Mid-slot digit change inside slot 0
        repeat (2) step();
        ifc.sec_o = 4'd6;
        repeat (4 * SD) step();

        // Randomized traffic
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                ifc.min_t = 4'($urandom_range(0, 15));
                ifc.min_o = 4'($urandom_range(0, 15));
                ifc.sec_t = 4'($urandom_range(0, 15));
                ifc.sec_o = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) ifc.adj     = ~ifc.adj;
            if ($urandom_range(0, 7) == 0) ifc.sel     = ~ifc.sel;
            if ($urandom_range(0, 5) == 0) ifc.clk_2hz = ~ifc.clk_2hz;
            step();
        end

        async_reset_mid("rst_rand");
        repeat (4 * SD + 3) begin
            ifc.adj     = 1'($urandom_range(0, 1));
            ifc.clk_2hz = 1'($urandom_range(0, 1));
            step();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed 4-digit 7-segment driver directly downstream of the stopwatch `counter`. It consumes the four BCD digit buses (`min_t_w`, `min_o_w`, `sec_t_w`, `sec_o_w`) plus the `adj`/`sel` mode bits, and produces active-low anode and cathode drives for the board display. In adjust mode it blinks the selected field at the 2 Hz rate. All outputs are registered, and a blanking interval at the start of each digit slot suppresses ghosting.

## Interface
- `SCAN_DIV`, 100000: `clk` cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 4: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `clk` in 1: system clock; the block has one clock.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `clk_2hz` in 1: blink phase from the clock divider; asynchronous to the block, treated as data.
- `min_t` in 4: minutes tens digit, BCD.
- `min_o` in 4: minutes ones digit, BCD.
- `sec_t` in 4: seconds tens digit, BCD.
- `sec_o` in 4: seconds ones digit, BCD.
- `adj` in 1: adjust mode active.
- `sel` in 1: adjust field select; 0 = minutes, 1 = seconds.
- `an` out 4: anode enables, active-low; `an[3]` = leftmost digit.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Scan counter `cnt` runs 0..`SCAN_DIV`-1 and wraps. On wrap, slot index `idx` advances 0→1→2→3→0.
- Slot-to-digit mapping:
  - `idx` 0 → `an`=1110, digit `sec_o`
  - `idx` 1 → `an`=1101, digit `sec_t`
  - `idx` 2 → `an`=1011, digit `min_o`
  - `idx` 3 → `an`=0111, digit `min_t`
- Blanking: while `cnt` < `BLANK_CYC`, `an`=1111. `seg` and `dp` already carry the new slot's value.
- Decode: values 0–9 use the standard glyphs. Values 10–15 show a dash (`seg`=0111111).
- `dp` is low only in slot 2, forming the separator between minutes and seconds.
- Blink:
  - `clk_2hz` passes through a 2-FF synchroniser to give `blink`.
  - If `adj`=1 and `blink`=1, the two digits of the selected field are blanked: `seg`=1111111 and `dp`=1, while the anode stays enabled.
  - `sel`=0 blanks slots 2–3; `sel`=1 blanks slots 0–1.
  - When `adj`=0 nothing is blanked.
- Digit, `adj` and `sel` inputs are sampled every cycle. A change mid-slot appears on `seg` on the next cycle; there is no slot-boundary latching.

## Timing
- Reset (`rst`=0, asynchronous): `cnt`=0, `idx`=0, synchroniser flops=0, `an`=1111, `seg`=1111111, `dp`=1.
- After reset release, the first rising edge begins slot 0. `an` stays 1111 for `BLANK_CYC` cycles after that edge.
- Output latency is one cycle from `cnt`/`idx`/input to `an`/`seg`/`dp`. All outputs come straight from flops.
- `blink` lags `clk_2hz` by 2–3 `clk` edges.
- Full digit frame is 4·`SCAN_DIV` cycles. Slot wrap 3→0 has no extra gap.
- Reset asserted mid-slot forces all outputs to reset values immediately, without waiting for a clock. The scan restarts at slot 0.
- A simultaneous `adj` rise and slot change takes effect on the same cycle, with no priority issue, since both feed the same register stage.

## Structure
- Shared package `seg_pkg` holds the glyph constants `SEG_0`..`SEG_9`, `SEG_DASH` and `SEG_OFF`, plus the anode patterns and the slot index type (2-bit).
- Sub-module `bcd_to_seg` is a combinational 4-bit → 7-bit decoder, instantiated once on the muxed digit.
- The top level contains the scan counter, slot register, synchroniser, blink/blank logic and output registers.

## Test plan
All scenarios use `SCAN_DIV`=4 and `BLANK_CYC`=1.
- Reset and scan order: inputs 1,2,3,4 (`min_t`..`sec_o`), release `rst` → `an` steps 1111 then 1110 / 1101 / 1011 / 0111 with 1111 for 1 cycle per slot. `seg`=SEG_4 / SEG_3 / SEG_2 / SEG_1. `dp`=0 only in slot 2.
- Invalid BCD: `sec_o`=4'hC → slot 0 `seg`=0111111.
- Blink seconds: `adj`=1, `sel`=1, hold `clk_2hz`=1 → after 3 cycles, slots 0–1 show `seg`=1111111 and slots 2–3 are normal. Set `clk_2hz`=0 → all slots normal within 3 cycles.
- Blink minutes: `adj`=1, `sel`=0, `clk_2hz`=1 → slots 2–3 are blanked, including `dp`=1. Set `adj`=0 → no blanking.
- Async reset mid-slot: drop `rst` between clock edges during slot 2 → `an`=1111 and `seg`=1111111 immediately. After release, the scan resumes at slot 0.
- Mid-slot input change: change `sec_o` from 5 to 6 during slot 0 → `seg` shows SEG_6 one cycle later, within the same slot.
